formant_freq_tracker: RTL and testbench

- Downstream consumer of the phi stage.
- Captures the four per-formant phase angles when the phi stage pulses output_valid.
- Converts each angle to an integer frequency in Hz using one shared multiplier, time-multiplexed.
- Applies per-formant exponential smoothing across frames, flags non-monotonic formant ordering, and presents a registered frequency frame with a one-cycle valid strobe.

---
 rtl/formant_freq_tracker.sv | 203 ++++++++++++++++++++
 tb/tb_formant_freq_tracker.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/formant_freq_tracker.sv
// -----------------------------------------------------------------------------
// formant_freq_tracker
//
// Converts the four per-formant phase angles produced by the phi stage into
// smoothed integer frequencies in Hz.
//
// Processing of a frame, where phi_valid is sampled at edge T:
//   T        latch phi_1..4, busy goes high
//   T+1..T+4 one shared multiplier converts lane k = 0..3 to raw Hz
//   T+5      exponential smoothing of all lanes plus the ordering check
//   T+6      registered frame loaded, freq_valid high for one cycle
//   T+7      busy drops, a new frame may be accepted from T+8 onwards
//
// Ports
//   clk_in         system clock
//   rst_in         synchronous, active-high reset
//   phi_1..phi_4   unsigned angles, full scale 2^BIT_WIDTH represents pi rad
//   phi_valid      single-cycle frame strobe from the phi stage
//   freq_1..freq_4 smoothed frequencies in Hz, held between frames
//   freq_valid     one-cycle strobe marking a new frequency frame
//   busy           high while a frame is in flight, through freq_valid
//   order_error    raw frequencies of the last frame were not non-decreasing
//   overrun        sticky: a phi_valid arrived while busy and was dropped
// -----------------------------------------------------------------------------
module formant_freq_tracker #(
  parameter int BIT_WIDTH   = 32,
  parameter int FORMANTS    = 4,     // lane logic below is built for 4 lanes
  parameter int MAX_FREQ    = 5000,
  parameter int FREQ_WIDTH  = 16,
  parameter int ALPHA_SHIFT = 2
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic [BIT_WIDTH-1:0]  phi_1,
  input  logic [BIT_WIDTH-1:0]  phi_2,
  input  logic [BIT_WIDTH-1:0]  phi_3,
  input  logic [BIT_WIDTH-1:0]  phi_4,
  input  logic                  phi_valid,
  output logic [FREQ_WIDTH-1:0] freq_1,
  output logic [FREQ_WIDTH-1:0] freq_2,
  output logic [FREQ_WIDTH-1:0] freq_3,
  output logic [FREQ_WIDTH-1:0] freq_4,
  output logic                  freq_valid,
  output logic                  busy,
  output logic                  order_error,
  output logic                  overrun
);

  // Product of a BIT_WIDTH angle and MAX_FREQ plus the rounding half;
  // MAX_FREQ is far below 2^BIT_WIDTH so this never overflows.
  localparam int PROD_W = 2 * BIT_WIDTH;

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    SMOOTH,
    OUT
  } state_t;

  state_t state, state_nxt;
  logic [1:0] lane, lane_nxt;
  logic       accept;
  logic       primed;

  logic [BIT_WIDTH-1:0]  phi_q   [FORMANTS];
  logic [FREQ_WIDTH-1:0] raw_q   [FORMANTS];
  logic [FREQ_WIDTH-1:0] y_q     [FORMANTS];
  logic [FREQ_WIDTH-1:0] y_smooth[FORMANTS];
  logic [FREQ_WIDTH-1:0] freq_q  [FORMANTS];

  logic [BIT_WIDTH-1:0]  phi_sel;
  logic [PROD_W-1:0]     product;
  logic [PROD_W-1:0]     scaled;
  logic [FREQ_WIDTH-1:0] raw_mul;

  // busy still covers the freq_valid cycle, so a strobe there is dropped.
  assign accept = (state == IDLE) && phi_valid && !busy;

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_in) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    if (rst_in) begin
      state <= IDLE;
      lane  <= '0;
    end else begin
      state <= state_nxt;
      lane  <= lane_nxt;
    end
  end

  always_comb begin
    // NOTE: defaults first, so no path leaves a signal unassigned and no
    // latch is inferred.
    state_nxt = state;
    lane_nxt  = lane;
    unique case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = MUL;
          lane_nxt  = '0;
        end
      end
      MUL: begin
        lane_nxt = lane + 2'd1;
        if (lane == 2'd3) state_nxt = SMOOTH;
      end
      SMOOTH:  state_nxt = OUT;
      OUT:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Shared multiplier: angle -> Hz with round-half-up and clamp at MAX_FREQ
  // ---------------------------------------------------------------------------
  always_comb begin
    phi_sel = phi_q[lane];
    product = PROD_W'(phi_sel) * PROD_W'(MAX_FREQ)
            + (PROD_W'(1) << (BIT_WIDTH - 1));
    scaled  = product >> BIT_WIDTH;
    raw_mul = (scaled > PROD_W'(MAX_FREQ)) ? FREQ_WIDTH'(MAX_FREQ)
                                           : FREQ_WIDTH'(scaled);
  end

  // ---------------------------------------------------------------------------
  // Smoothing: y += (raw - y) >>> ALPHA_SHIFT, floor shift on a signed
  // difference, so small rises stall while falls always move at least 1 LSB.
  // The result stays between y and raw, hence inside [0, MAX_FREQ].
  // ---------------------------------------------------------------------------
  always_comb begin
    logic signed [FREQ_WIDTH:0] diff;
    logic signed [FREQ_WIDTH:0] step;
    logic signed [FREQ_WIDTH:0] sum;
    diff = '0;
    step = '0;
    sum  = '0;
    for (int k = 0; k < FORMANTS; k++) begin
      diff = $signed({1'b0, raw_q[k]}) - $signed({1'b0, y_q[k]});
      step = diff >>> ALPHA_SHIFT;
      sum  = $signed({1'b0, y_q[k]}) + step;
      y_smooth[k] = (!primed || (ALPHA_SHIFT == 0)) ? raw_q[k]
                                                    : FREQ_WIDTH'(sum);
    end
  end

  // ---------------------------------------------------------------------------
  // Working storage
  // ---------------------------------------------------------------------------
  // NOTE: these arrays carry no reset; each entry is written before it is
  // read in a frame, and y_q is ignored until primed is set.
  always_ff @(posedge clk_in) begin
    if (accept) begin
      phi_q[0] <= phi_1;
      phi_q[1] <= phi_2;
      phi_q[2] <= phi_3;
      phi_q[3] <= phi_4;
    end
    if (state == MUL) raw_q[lane] <= raw_mul;
    if (state == SMOOTH) begin
      for (int k = 0; k < FORMANTS; k++) y_q[k] <= y_smooth[k];
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs and status
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      for (int k = 0; k < FORMANTS; k++) freq_q[k] <= '0;
      freq_valid  <= 1'b0;
      busy        <= 1'b0;
      order_error <= 1'b0;
      overrun     <= 1'b0;
      primed      <= 1'b0;
    end else begin
      freq_valid <= (state == OUT);

      if (accept)          busy <= 1'b1;
      else if (freq_valid) busy <= 1'b0;

      if (phi_valid && busy) overrun <= 1'b1;

      if (state == SMOOTH) begin
        order_error <= (raw_q[0] > raw_q[1]) | (raw_q[1] > raw_q[2])
                     | (raw_q[2] > raw_q[3]);
        primed      <= 1'b1;
      end

      if (state == OUT) begin
        for (int k = 0; k < FORMANTS; k++) freq_q[k] <= y_q[k];
      end
    end
  end

  assign freq_1 = freq_q[0];
  assign freq_2 = freq_q[1];
  assign freq_3 = freq_q[2];
  assign freq_4 = freq_q[3];

endmodule

// File: tb/tb_formant_freq_tracker.sv
// -----------------------------------------------------------------------------
// Testbench for formant_freq_tracker. Two instances share clock, reset and
// inputs: dut_a0 (ALPHA_SHIFT=0, raw pass-through) and dut_a2 (ALPHA_SHIFT=2).
// Inputs change 1 time unit after the rising edge, outputs are read there too.
// -----------------------------------------------------------------------------
module tb_formant_freq_tracker;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        phi_valid;
  logic [31:0] phi_1, phi_2, phi_3, phi_4;

  logic [15:0] a_f1, a_f2, a_f3, a_f4;
  logic        a_fv, a_busy, a_oe, a_ov;
  logic [15:0] b_f1, b_f2, b_f3, b_f4;
  logic        b_fv, b_busy, b_oe, b_ov;

  always #5 clk_in = ~clk_in;

  formant_freq_tracker #(.ALPHA_SHIFT(0)) dut_a0 (
    .clk_in(clk_in), .rst_in(rst_in),
    .phi_1(phi_1), .phi_2(phi_2), .phi_3(phi_3), .phi_4(phi_4),
    .phi_valid(phi_valid),
    .freq_1(a_f1), .freq_2(a_f2), .freq_3(a_f3), .freq_4(a_f4),
    .freq_valid(a_fv), .busy(a_busy), .order_error(a_oe), .overrun(a_ov)
  );

  formant_freq_tracker #(.ALPHA_SHIFT(2)) dut_a2 (
    .clk_in(clk_in), .rst_in(rst_in),
    .phi_1(phi_1), .phi_2(phi_2), .phi_3(phi_3), .phi_4(phi_4),
    .phi_valid(phi_valid),
    .freq_1(b_f1), .freq_2(b_f2), .freq_3(b_f3), .freq_4(b_f4),
    .freq_valid(b_fv), .busy(b_busy), .order_error(b_oe), .overrun(b_ov)
  );

  typedef struct {
    logic [31:0] phi  [4];
    logic [15:0] freq [4];
    logic        oe;
  } vec_t;

  int checks   = 0;
  int failures = 0;

  // freq_valid pulse monitor for dut_a0, sampled on the falling edge.
  int   fv_pulses = 0;
  int   fv_wide   = 0;
  logic fv_prev   = 1'b0;
  always @(negedge clk_in) begin
    if (a_fv) begin
      fv_pulses++;
      if (fv_prev) fv_wide++;
    end
    fv_prev = a_fv;
  end

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic do_reset();
    rst_in    = 1'b1;
    phi_valid = 1'b0;
    step();
    step();
    rst_in = 1'b0;
  endtask

  task automatic set_phi(input logic [31:0] p [4]);
    phi_1 = p[0];
    phi_2 = p[1];
    phi_3 = p[2];
    phi_4 = p[3];
  endtask

  // One-cycle strobe, then follow dut_a0 until busy drops. lat counts edges
  // after the sampling edge until freq_valid is seen (-1 if never).
  task automatic run_frame(input logic [31:0] p [4], output int lat,
                           output int busy_cyc);
    set_phi(p);
    phi_valid = 1'b1;
    step();
    phi_valid = 1'b0;
    lat      = -1;
    busy_cyc = 0;
    for (int i = 0; i < 30; i++) begin
      if (a_busy) busy_cyc++;
      if (a_fv && lat < 0) lat = i;
      if (!a_busy) break;
      step();
    end
  endtask

  task automatic check_a(input string name, input logic [15:0] e [4]);
    check({name, "_a_f1"}, 32'(a_f1), 32'(e[0]));
    check({name, "_a_f2"}, 32'(a_f2), 32'(e[1]));
    check({name, "_a_f3"}, 32'(a_f3), 32'(e[2]));
    check({name, "_a_f4"}, 32'(a_f4), 32'(e[3]));
  endtask

  task automatic check_b(input string name, input logic [15:0] e [4]);
    check({name, "_b_f1"}, 32'(b_f1), 32'(e[0]));
    check({name, "_b_f2"}, 32'(b_f2), 32'(e[1]));
    check({name, "_b_f3"}, 32'(b_f3), 32'(e[2]));
    check({name, "_b_f4"}, 32'(b_f4), 32'(e[3]));
  endtask

  vec_t        vecs [5];
  logic [31:0] p2000 [4] = '{32'h6666_6666, 32'h6666_6666, 32'h6666_6666, 32'h6666_6666};
  logic [31:0] p3000 [4] = '{32'h9999_999A, 32'h9999_999A, 32'h9999_999A, 32'h9999_999A};
  logic [31:0] pzero [4] = '{32'h0, 32'h0, 32'h0, 32'h0};

  initial begin
    int lat, bcyc, p0, w0, n, first, last;

    // phi -> Hz: (phi*5000 + 2^31) >> 32, clamped at 5000.
    vecs[0].phi  = '{32'h2000_0000, 32'h4000_0000, 32'h8000_0000, 32'hFFFF_FFFF};
    vecs[0].freq = '{16'd625, 16'd1250, 16'd2500, 16'd5000};
    vecs[0].oe   = 1'b0;
    vecs[1].phi  = '{32'h8000_0000, 32'h4000_0000, 32'hC000_0000, 32'hFFFF_FFFF};
    vecs[1].freq = '{16'd2500, 16'd1250, 16'd3750, 16'd5000};
    vecs[1].oe   = 1'b1;
    // 429496 lands just below 0.5 Hz, 429497 just above; 2^28 is 312.5 Hz.
    vecs[2].phi  = '{32'd0, 32'd429496, 32'd429497, 32'h1000_0000};
    vecs[2].freq = '{16'd0, 16'd0, 16'd1, 16'd313};
    vecs[2].oe   = 1'b0;
    vecs[3].phi  = '{32'hFFFF_FFFF, 32'h8000_0000, 32'h4000_0000, 32'h0};
    vecs[3].freq = '{16'd5000, 16'd2500, 16'd1250, 16'd0};
    vecs[3].oe   = 1'b1;
    vecs[4].phi  = '{32'h6666_6666, 32'h6666_6666, 32'h9999_999A, 32'h9999_999A};
    vecs[4].freq = '{16'd2000, 16'd2000, 16'd3000, 16'd3000};
    vecs[4].oe   = 1'b0;

    phi_valid = 1'b0;
    set_phi(pzero);
    do_reset();

    // Reset state.
    check("rst_a_outs", {a_f1, a_f2}, 32'd0);
    check("rst_a_outs2", {a_f3, a_f4}, 32'd0);
    check("rst_a_flags", {28'd0, a_fv, a_busy, a_oe, a_ov}, 32'd0);
    check("rst_b_flags", {28'd0, b_fv, b_busy, b_oe, b_ov}, 32'd0);

    // Table: raw conversion, ordering flag, latency and busy width.
    foreach (vecs[v]) begin
      run_frame(vecs[v].phi, lat, bcyc);
      check($sformatf("vec%0d_latency", v), 32'(lat), 32'd6);
      check($sformatf("vec%0d_busy_cycles", v), 32'(bcyc), 32'd7);
      check_a($sformatf("vec%0d", v), vecs[v].freq);
      check($sformatf("vec%0d_order_error", v), 32'(a_oe), 32'(vecs[v].oe));
    end
    check("table_no_overrun", 32'(a_ov), 32'd0);

    // Smoothing on dut_a2 from an unprimed state.
    do_reset();
    run_frame(p2000, lat, bcyc);
    check_b("smooth_f1", '{16'd2000, 16'd2000, 16'd2000, 16'd2000});
    run_frame(p3000, lat, bcyc);
    check_b("smooth_f2", '{16'd2250, 16'd2250, 16'd2250, 16'd2250});
    run_frame(p3000, lat, bcyc);
    check_b("smooth_f3", '{16'd2437, 16'd2437, 16'd2437, 16'd2437});
    // Falling: -2437 >>> 2 floors to -610.
    run_frame(pzero, lat, bcyc);
    check_b("smooth_fall", '{16'd1827, 16'd1827, 16'd1827, 16'd1827});
    check_a("smooth_raw_a0", '{16'd0, 16'd0, 16'd0, 16'd0});

    // Mid-frame reset aborts the frame and clears primed.
    set_phi(p3000);
    phi_valid = 1'b1;
    step();
    phi_valid = 1'b0;
    step();
    step();
    p0 = fv_pulses;
    rst_in = 1'b1;
    step();
    step();
    rst_in = 1'b0;
    for (int i = 0; i < 15; i++) step();
    check("abort_no_fv", 32'(fv_pulses - p0), 32'd0);
    check_a("abort_zero", '{16'd0, 16'd0, 16'd0, 16'd0});
    check_b("abort_zero", '{16'd0, 16'd0, 16'd0, 16'd0});
    check("abort_flags", {28'd0, a_fv, a_busy, a_oe, a_ov}, 32'd0);
    run_frame(p2000, lat, bcyc);
    check_b("abort_unprimed", '{16'd2000, 16'd2000, 16'd2000, 16'd2000});

    // Overrun: second strobe 3 cycles after the first is dropped.
    do_reset();
    set_phi(vecs[0].phi);
    phi_valid = 1'b1;
    step();
    phi_valid = 1'b0;
    step();
    step();
    set_phi(vecs[3].phi);
    phi_valid = 1'b1;
    step();
    phi_valid = 1'b0;
    p0 = fv_pulses;
    for (int i = 0; i < 15; i++) step();
    check("ovr_single_fv", 32'(fv_pulses - p0), 32'd1);
    check_a("ovr_first_frame", vecs[0].freq);
    check("ovr_set", 32'(a_ov), 32'd1);
    run_frame(vecs[4].phi, lat, bcyc);
    run_frame(vecs[2].phi, lat, bcyc);
    check("ovr_sticky", 32'(a_ov), 32'd1);
    check_a("ovr_later_frame", vecs[2].freq);
    do_reset();
    check("ovr_cleared", 32'(a_ov), 32'd0);

    // phi_valid held high for 20 cycles: accepts at edges 0, 8, 16.
    set_phi(vecs[0].phi);
    phi_valid = 1'b1;
    n = 0;
    first = -1;
    last  = -1;
    w0 = fv_wide;
    for (int i = 0; i < 40; i++) begin
      if (i == 20) phi_valid = 1'b0;
      step();
      if (a_fv) begin
        n++;
        if (first < 0) first = i;
        last = i;
      end
    end
    check("held_frames", 32'(n), 32'd3);
    check("held_first_fv", 32'(first), 32'd6);
    check("held_last_fv", 32'(last), 32'd22);
    check("held_overrun", 32'(a_ov), 32'd1);
    check("held_idle", 32'(a_busy), 32'd0);
    check_a("held_values", vecs[0].freq);
    check("fv_single_cycle", 32'(fv_wide - w0), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
